// File: rtl/ball_motion_controller.sv
// ball_motion_controller
// Per-frame ball kinematics engine. On each frame tick the ball advances along
// its heading (degrees 0..359, +x = 0, +y = 90) using a quarter-wave sine ROM.
// Friction is applied once per frame. When the ball crosses a table wall, the
// crossed coordinate is clamped to that wall and the external reflection helper
// supplies the new heading, one axis per cycle with x before y.
//
// Ports
//   clk_in, rst_in          clock, asynchronous active-high reset
//   frame_tick_in           one-cycle pulse per video frame
//   launch_valid_in/ready   launch handshake (ready only in IDLE)
//   launch_dir/speed/x/y_in launch heading, speed (1/64 px per frame), start pos
//   ball_dir_out            current heading, to helper
//   wall_dir_out            wall being reflected (0=+x 1=+y 2=-x 3=-y), to helper
//   refl_dir_in             helper's new heading, combinational in the same cycle
//   pos_x_out, pos_y_out    ball position in whole pixels
//   moving_out              speed is non-zero
//   step_done_out           pulse when a frame update completes
//   bounce_out              pulse per reflection applied
module ball_motion_controller #(
  parameter int X_MIN     = 16,
  parameter int X_MAX     = 1007,
  parameter int Y_MIN     = 16,
  parameter int Y_MAX     = 495,
  parameter int FRAC_BITS = 6,
  parameter int FRICTION  = 1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        frame_tick_in,
  input  logic        launch_valid_in,
  input  logic [15:0] launch_dir_in,
  input  logic [7:0]  launch_speed_in,
  input  logic [9:0]  launch_x_in,
  input  logic [9:0]  launch_y_in,
  output logic        launch_ready_out,
  output logic [15:0] ball_dir_out,
  output logic [1:0]  wall_dir_out,
  input  logic [15:0] refl_dir_in,
  output logic [9:0]  pos_x_out,
  output logic [9:0]  pos_y_out,
  output logic        moving_out,
  output logic        step_done_out,
  output logic        bounce_out
);

  localparam int unsigned PW = 17;  // internal fixed-point position width
  localparam int unsigned AW = 9;   // heading width, 0..359
  localparam int unsigned SW = 8;   // speed width

  localparam logic signed [PW-1:0] XMIN_S  = PW'(X_MIN);
  localparam logic signed [PW-1:0] XMAX_S  = PW'(X_MAX);
  localparam logic signed [PW-1:0] YMIN_S  = PW'(Y_MIN);
  localparam logic signed [PW-1:0] YMAX_S  = PW'(Y_MAX);
  localparam logic [PW-1:0]        XMIN_FP = PW'(X_MIN << FRAC_BITS);
  localparam logic [PW-1:0]        XMAX_FP = PW'(X_MAX << FRAC_BITS);
  localparam logic [PW-1:0]        YMIN_FP = PW'(Y_MIN << FRAC_BITS);
  localparam logic [PW-1:0]        YMAX_FP = PW'(Y_MAX << FRAC_BITS);
  localparam logic [SW-1:0]        FRIC    = SW'(FRICTION);

  typedef enum logic [2:0] {
    IDLE, MOVING, STEP, CHECK, REFLECT_X, REFLECT_Y, UPDATE
  } state_t;

  state_t           state;
  logic [PW-1:0]    pos_x;
  logic [PW-1:0]    pos_y;
  logic [AW-1:0]    dir;
  logic [SW-1:0]    speed;
  logic             y_cross_q;
  logic [1:0]       y_wall_q;

  // round(256 * sin(a)) for a = 0..90 degrees
  function automatic logic [8:0] sin_rom(input logic [6:0] a);
    case (a)
      7'd0:  sin_rom = 9'd0;   7'd1:  sin_rom = 9'd4;   7'd2:  sin_rom = 9'd9;
      7'd3:  sin_rom = 9'd13;  7'd4:  sin_rom = 9'd18;  7'd5:  sin_rom = 9'd22;
      7'd6:  sin_rom = 9'd27;  7'd7:  sin_rom = 9'd31;  7'd8:  sin_rom = 9'd36;
      7'd9:  sin_rom = 9'd40;  7'd10: sin_rom = 9'd44;  7'd11: sin_rom = 9'd49;
      7'd12: sin_rom = 9'd53;  7'd13: sin_rom = 9'd58;  7'd14: sin_rom = 9'd62;
      7'd15: sin_rom = 9'd66;  7'd16: sin_rom = 9'd71;  7'd17: sin_rom = 9'd75;
      7'd18: sin_rom = 9'd79;  7'd19: sin_rom = 9'd83;  7'd20: sin_rom = 9'd88;
      7'd21: sin_rom = 9'd92;  7'd22: sin_rom = 9'd96;  7'd23: sin_rom = 9'd100;
      7'd24: sin_rom = 9'd104; 7'd25: sin_rom = 9'd108; 7'd26: sin_rom = 9'd112;
      7'd27: sin_rom = 9'd116; 7'd28: sin_rom = 9'd120; 7'd29: sin_rom = 9'd124;
      7'd30: sin_rom = 9'd128; 7'd31: sin_rom = 9'd132; 7'd32: sin_rom = 9'd136;
      7'd33: sin_rom = 9'd139; 7'd34: sin_rom = 9'd143; 7'd35: sin_rom = 9'd147;
      7'd36: sin_rom = 9'd150; 7'd37: sin_rom = 9'd154; 7'd38: sin_rom = 9'd158;
      7'd39: sin_rom = 9'd161; 7'd40: sin_rom = 9'd165; 7'd41: sin_rom = 9'd168;
      7'd42: sin_rom = 9'd171; 7'd43: sin_rom = 9'd175; 7'd44: sin_rom = 9'd178;
      7'd45: sin_rom = 9'd181; 7'd46: sin_rom = 9'd184; 7'd47: sin_rom = 9'd187;
      7'd48: sin_rom = 9'd190; 7'd49: sin_rom = 9'd193; 7'd50: sin_rom = 9'd196;
      7'd51: sin_rom = 9'd199; 7'd52: sin_rom = 9'd202; 7'd53: sin_rom = 9'd204;
      7'd54: sin_rom = 9'd207; 7'd55: sin_rom = 9'd210; 7'd56: sin_rom = 9'd212;
      7'd57: sin_rom = 9'd215; 7'd58: sin_rom = 9'd217; 7'd59: sin_rom = 9'd219;
      7'd60: sin_rom = 9'd222; 7'd61: sin_rom = 9'd224; 7'd62: sin_rom = 9'd226;
      7'd63: sin_rom = 9'd228; 7'd64: sin_rom = 9'd230; 7'd65: sin_rom = 9'd232;
      7'd66: sin_rom = 9'd234; 7'd67: sin_rom = 9'd236; 7'd68: sin_rom = 9'd237;
      7'd69: sin_rom = 9'd239; 7'd70: sin_rom = 9'd241; 7'd71: sin_rom = 9'd242;
      7'd72: sin_rom = 9'd243; 7'd73: sin_rom = 9'd245; 7'd74: sin_rom = 9'd246;
      7'd75: sin_rom = 9'd247; 7'd76: sin_rom = 9'd248; 7'd77: sin_rom = 9'd249;
      7'd78: sin_rom = 9'd250; 7'd79: sin_rom = 9'd251; 7'd80: sin_rom = 9'd252;
      7'd81: sin_rom = 9'd253; 7'd82: sin_rom = 9'd254; 7'd83: sin_rom = 9'd254;
      7'd84: sin_rom = 9'd255; 7'd85: sin_rom = 9'd255; 7'd86: sin_rom = 9'd255;
      default: sin_rom = 9'd256;
    endcase
  endfunction

  // Quadrant folding: magnitude of cos/sin plus direction of travel per axis
  logic [6:0]    ang_c;
  logic [8:0]    sin_a_c;
  logic [8:0]    cos_a_c;
  logic [8:0]    mag_x_c;
  logic [8:0]    mag_y_c;
  logic          neg_x_c;
  logic          neg_y_c;

  always_comb begin
    ang_c   = 7'd0;
    neg_x_c = 1'b0;
    neg_y_c = 1'b0;
    if (dir < 9'd90) begin
      ang_c = 7'(dir);
    end else if (dir < 9'd180) begin
      ang_c   = 7'(dir - 9'd90);
      neg_x_c = 1'b1;
    end else if (dir < 9'd270) begin
      ang_c   = 7'(dir - 9'd180);
      neg_x_c = 1'b1;
      neg_y_c = 1'b1;
    end else begin
      ang_c   = 7'(dir - 9'd270);
      neg_y_c = 1'b1;
    end
    sin_a_c = sin_rom(ang_c);
    cos_a_c = sin_rom(7'(7'd90 - ang_c));
    // Odd quadrants swap the roles of sin and cos of the folded angle
    if (dir >= 9'd90 && dir < 9'd180 || dir >= 9'd270) begin
      mag_x_c = sin_a_c;
      mag_y_c = cos_a_c;
    end else begin
      mag_x_c = cos_a_c;
      mag_y_c = sin_a_c;
    end
  end

  // Per-frame displacement and the stepped position
  logic [8:0]    dx_c;
  logic [8:0]    dy_c;
  logic [PW-1:0] step_x_c;
  logic [PW-1:0] step_y_c;

  always_comb begin
    dx_c     = 9'((PW'(speed) * PW'(mag_x_c)) >> 8);
    dy_c     = 9'((PW'(speed) * PW'(mag_y_c)) >> 8);
    step_x_c = neg_x_c ? pos_x - PW'(dx_c) : pos_x + PW'(dx_c);
    step_y_c = neg_y_c ? pos_y - PW'(dy_c) : pos_y + PW'(dy_c);
  end

  // Wall crossing on the signed pixel coordinate (negative means underflow)
  logic signed [PW-1:0] px_c;
  logic signed [PW-1:0] py_c;
  logic                 x_hi_c;
  logic                 x_lo_c;
  logic                 y_hi_c;
  logic                 y_lo_c;

  always_comb begin
    px_c   = $signed(pos_x) >>> FRAC_BITS;
    py_c   = $signed(pos_y) >>> FRAC_BITS;
    x_hi_c = px_c > XMAX_S;
    x_lo_c = px_c < XMIN_S;
    y_hi_c = py_c > YMAX_S;
    y_lo_c = py_c < YMIN_S;
  end

  // Heading normalisation and friction
  logic [AW-1:0] launch_dir_c;
  logic [AW-1:0] refl_dir_c;
  logic [SW-1:0] speed_nxt_c;

  always_comb begin
    launch_dir_c = AW'(launch_dir_in % 16'd360);
    refl_dir_c   = (refl_dir_in >= 16'd360) ? AW'(refl_dir_in - 16'd360)
                                            : AW'(refl_dir_in);
    speed_nxt_c  = (speed > FRIC) ? speed - FRIC : SW'(0);
  end

  assign ball_dir_out = 16'(dir);

  // Main FSM with registered outputs
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state            <= IDLE;
      pos_x            <= XMIN_FP;
      pos_y            <= YMIN_FP;
      dir              <= '0;
      speed            <= '0;
      y_cross_q        <= 1'b0;
      y_wall_q         <= 2'd0;
      wall_dir_out     <= 2'd0;
      pos_x_out        <= 10'(X_MIN);
      pos_y_out        <= 10'(Y_MIN);
      moving_out       <= 1'b0;
      step_done_out    <= 1'b0;
      bounce_out       <= 1'b0;
      launch_ready_out <= 1'b1;
    end else begin
      step_done_out <= 1'b0;
      bounce_out    <= 1'b0;
      case (state)
        IDLE: begin
          if (launch_valid_in) begin
            pos_x     <= PW'(launch_x_in) << FRAC_BITS;
            pos_y     <= PW'(launch_y_in) << FRAC_BITS;
            pos_x_out <= launch_x_in;
            pos_y_out <= launch_y_in;
            dir       <= launch_dir_c;
            speed     <= launch_speed_in;
            if (launch_speed_in != '0) begin
              state            <= MOVING;
              moving_out       <= 1'b1;
              launch_ready_out <= 1'b0;
            end
          end
        end
        MOVING: begin
          if (frame_tick_in) state <= STEP;
        end
        STEP: begin
          pos_x <= step_x_c;
          pos_y <= step_y_c;
          state <= CHECK;
        end
        CHECK: begin
          if (x_hi_c) begin
            pos_x     <= XMAX_FP;
            pos_x_out <= 10'(X_MAX);
          end else if (x_lo_c) begin
            pos_x     <= XMIN_FP;
            pos_x_out <= 10'(X_MIN);
          end else begin
            pos_x_out <= 10'(px_c);
          end
          if (y_hi_c) begin
            pos_y     <= YMAX_FP;
            pos_y_out <= 10'(Y_MAX);
          end else if (y_lo_c) begin
            pos_y     <= YMIN_FP;
            pos_y_out <= 10'(Y_MIN);
          end else begin
            pos_y_out <= 10'(py_c);
          end
          y_cross_q <= y_hi_c | y_lo_c;
          y_wall_q  <= y_hi_c ? 2'd1 : 2'd3;
          // wall_dir_out must be valid during the reflect cycle itself
          if (x_hi_c | x_lo_c) begin
            wall_dir_out <= x_hi_c ? 2'd0 : 2'd2;
            state        <= REFLECT_X;
          end else if (y_hi_c | y_lo_c) begin
            wall_dir_out <= y_hi_c ? 2'd1 : 2'd3;
            state        <= REFLECT_Y;
          end else begin
            step_done_out <= 1'b1;
            state         <= UPDATE;
          end
        end
        REFLECT_X: begin
          dir        <= refl_dir_c;
          bounce_out <= 1'b1;
          if (y_cross_q) begin
            wall_dir_out <= y_wall_q;
            state        <= REFLECT_Y;
          end else begin
            step_done_out <= 1'b1;
            state         <= UPDATE;
          end
        end
        REFLECT_Y: begin
          dir           <= refl_dir_c;
          bounce_out    <= 1'b1;
          step_done_out <= 1'b1;
          state         <= UPDATE;
        end
        UPDATE: begin
          speed      <= speed_nxt_c;
          moving_out <= (speed_nxt_c != '0);
          if (speed_nxt_c == '0) begin
            state            <= IDLE;
            launch_ready_out <= 1'b1;
          end else begin
            state <= MOVING;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ball_motion_controller.sv
// Directed testbench for ball_motion_controller with a behavioural reflection
// helper: x walls mirror the heading about 90 deg ((540-d) mod 360), y walls
// return 360-d unreduced so the controller's 360 -> 0 wrap is exercised.
module tb_ball_motion_controller;

  logic        clk;
  logic        rst;
  logic        tick;
  logic        lv;
  logic [15:0] ldir;
  logic [7:0]  lspd;
  logic [9:0]  lx;
  logic [9:0]  ly;
  logic        ready;
  logic [15:0] bdir;
  logic [1:0]  wall;
  logic [15:0] refl;
  logic [9:0]  px;
  logic [9:0]  py;
  logic        moving;
  logic        sdone;
  logic        bounce;

  int n_cmp = 0;
  int n_bad = 0;

  ball_motion_controller dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .frame_tick_in   (tick),
    .launch_valid_in (lv),
    .launch_dir_in   (ldir),
    .launch_speed_in (lspd),
    .launch_x_in     (lx),
    .launch_y_in     (ly),
    .launch_ready_out(ready),
    .ball_dir_out    (bdir),
    .wall_dir_out    (wall),
    .refl_dir_in     (refl),
    .pos_x_out       (px),
    .pos_y_out       (py),
    .moving_out      (moving),
    .step_done_out   (sdone),
    .bounce_out      (bounce)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    if (wall == 2'd0 || wall == 2'd2) refl = 16'((540 - int'(bdir)) % 360);
    else                              refl = 16'(360 - int'(bdir));
  end

  task automatic do_reset();
    tick = 1'b0; lv = 1'b0; ldir = '0; lspd = '0; lx = '0; ly = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic launch(input int x, input int y, input int d, input int s);
    @(negedge clk);
    lv = 1'b1; lx = 10'(x); ly = 10'(y); ldir = 16'(d); lspd = 8'(s);
    @(posedge clk);
    #1 lv = 1'b0;
  endtask

  // One frame tick; reports step_done latency (-1 if none), bounce count and
  // wall_dir seen in cycles 3 and 4 after the tick.
  task automatic run_tick(output int lat, output int nb, output logic [1:0] w3,
                          output logic [1:0] w4);
    lat = -1; nb = 0; w3 = 2'd0; w4 = 2'd0;
    @(negedge clk) tick = 1'b1;
    @(posedge clk);
    #1 tick = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      if (n == 3) w3 = wall;
      if (n == 4) w4 = wall;
      if (bounce) nb++;
      if (sdone && lat < 0) lat = n;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %0d exp 1", ready); end
    n_cmp++; if ({px, py} !== {10'd16, 10'd16}) begin n_bad++; $display("FAIL reset_pos got (%0d,%0d) exp (16,16)", px, py); end
    n_cmp++; if (bdir !== 16'd0) begin n_bad++; $display("FAIL reset_dir got %0d exp 0", bdir); end
    n_cmp++; if ({moving, sdone, bounce, wall} !== 5'd0) begin n_bad++; $display("FAIL reset_flags got %b exp 00000", {moving, sdone, bounce, wall}); end
  endtask

  task automatic test_straight();
    int lat, nb; logic [1:0] w3, w4;
    do_reset();
    launch(100, 100, 0, 64);
    n_cmp++; if ({ready, moving, px} !== {1'b0, 1'b1, 10'd100}) begin n_bad++; $display("FAIL launch_state got ready=%0d moving=%0d x=%0d exp 0 1 100", ready, moving, px); end
    run_tick(lat, nb, w3, w4);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL straight_latency got %0d exp 3", lat); end
    n_cmp++; if ({px, py} !== {10'd101, 10'd100}) begin n_bad++; $display("FAIL straight_pos got (%0d,%0d) exp (101,100)", px, py); end
    n_cmp++; if (nb !== 0 || bdir !== 16'd0) begin n_bad++; $display("FAIL straight_nobounce got nb=%0d dir=%0d exp 0 0", nb, bdir); end
  endtask

  task automatic test_launch_rules();
    do_reset();
    launch(50, 60, 390, 10);
    n_cmp++; if (bdir !== 16'd30) begin n_bad++; $display("FAIL launch_dir_mod got %0d exp 30", bdir); end
    launch(700, 400, 90, 20);
    n_cmp++; if ({px, py, bdir} !== {10'd50, 10'd60, 16'd30}) begin n_bad++; $display("FAIL launch_ignored got (%0d,%0d) dir %0d exp (50,60) dir 30", px, py, bdir); end
  endtask

  task automatic test_x_bounce();
    int lat, nb; logic [1:0] w3, w4;
    do_reset();
    launch(1007, 200, 30, 128);
    run_tick(lat, nb, w3, w4);
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL xb_latency got %0d exp 4", lat); end
    n_cmp++; if (w3 !== 2'd0) begin n_bad++; $display("FAIL xb_wall got %0d exp 0", w3); end
    n_cmp++; if ({bdir, px, py} !== {16'd150, 10'd1007, 10'd201}) begin n_bad++; $display("FAIL xb_result got dir %0d (%0d,%0d) exp dir 150 (1007,201)", bdir, px, py); end
    n_cmp++; if (nb !== 1) begin n_bad++; $display("FAIL xb_bounces got %0d exp 1", nb); end
  endtask

  task automatic test_corner();
    int lat, nb; logic [1:0] w3, w4;
    do_reset();
    launch(1007, 495, 45, 255);
    run_tick(lat, nb, w3, w4);
    n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL corner_latency got %0d exp 5", lat); end
    n_cmp++; if ({w3, w4} !== {2'd0, 2'd1}) begin n_bad++; $display("FAIL corner_walls got %0d,%0d exp 0,1", w3, w4); end
    n_cmp++; if ({bdir, px, py} !== {16'd225, 10'd1007, 10'd495}) begin n_bad++; $display("FAIL corner_result got dir %0d (%0d,%0d) exp dir 225 (1007,495)", bdir, px, py); end
    n_cmp++; if (nb !== 2) begin n_bad++; $display("FAIL corner_bounces got %0d exp 2", nb); end
  endtask

  task automatic test_y_bounce();
    int lat, nb; logic [1:0] w3, w4;
    do_reset();
    launch(300, 16, 270, 64);
    run_tick(lat, nb, w3, w4);
    n_cmp++; if ({lat, nb} !== {32'd4, 32'd1}) begin n_bad++; $display("FAIL yb_timing got lat %0d nb %0d exp 4 1", lat, nb); end
    n_cmp++; if (w3 !== 2'd3) begin n_bad++; $display("FAIL yb_wall got %0d exp 3", w3); end
    n_cmp++; if ({bdir, px, py} !== {16'd90, 10'd300, 10'd16}) begin n_bad++; $display("FAIL yb_result got dir %0d (%0d,%0d) exp dir 90 (300,16)", bdir, px, py); end
    // Heading 0 below the bottom wall: helper returns 360, stored as 0
    do_reset();
    launch(200, 15, 0, 64);
    run_tick(lat, nb, w3, w4);
    n_cmp++; if ({bdir, px, py} !== {16'd0, 10'd201, 10'd16}) begin n_bad++; $display("FAIL wrap360 got dir %0d (%0d,%0d) exp dir 0 (201,16)", bdir, px, py); end
    n_cmp++; if (nb !== 1) begin n_bad++; $display("FAIL wrap360_bounce got %0d exp 1", nb); end
  endtask

  task automatic test_friction();
    int lat, nb; logic [1:0] w3, w4;
    do_reset();
    launch(500, 300, 0, 3);
    for (int k = 1; k <= 3; k++) begin
      repeat (7) @(posedge clk);
      run_tick(lat, nb, w3, w4);
      n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL fric_latency step %0d got %0d exp 3", k, lat); end
      n_cmp++; if ({moving, ready} !== ((k < 3) ? 2'b10 : 2'b01)) begin n_bad++; $display("FAIL fric_state step %0d got moving=%0d ready=%0d", k, moving, ready); end
    end
    n_cmp++; if (px !== 10'd500) begin n_bad++; $display("FAIL fric_pos got %0d exp 500", px); end
    run_tick(lat, nb, w3, w4);
    n_cmp++; if (lat !== -1) begin n_bad++; $display("FAIL idle_tick got latency %0d exp -1", lat); end
    // Zero-speed launch stays idle
    launch(300, 300, 0, 0);
    n_cmp++; if ({ready, moving} !== 2'b10) begin n_bad++; $display("FAIL zero_speed got ready=%0d moving=%0d exp 1 0", ready, moving); end
  endtask

  task automatic test_back_to_back();
    int steps;
    do_reset();
    launch(100, 100, 0, 128);
    @(negedge clk) tick = 1'b1;
    @(posedge clk);
    #1 tick = 1'b0;
    steps = 0;
    // Second tick lands while the first update is in flight and must be dropped
    @(negedge clk) tick = 1'b1;
    @(posedge clk);
    #1 tick = 1'b0;
    for (int n = 0; n < 12; n++) begin
      if (sdone) steps++;
      @(posedge clk);
      #1;
    end
    n_cmp++; if (steps !== 1) begin n_bad++; $display("FAIL b2b_steps got %0d exp 1", steps); end
    n_cmp++; if (px !== 10'd102) begin n_bad++; $display("FAIL b2b_pos got %0d exp 102", px); end
  endtask

  task automatic test_reset_mid_reflect();
    int lat, nb; logic [1:0] w3, w4;
    do_reset();
    launch(1007, 495, 45, 255);
    @(negedge clk) tick = 1'b1;
    @(posedge clk);
    #1 tick = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({ready, moving, bounce, sdone} !== 4'b1000) begin n_bad++; $display("FAIL midrst_flags got %b exp 1000", {ready, moving, bounce, sdone}); end
    n_cmp++; if ({px, py, bdir} !== {10'd16, 10'd16, 16'd0}) begin n_bad++; $display("FAIL midrst_pos got (%0d,%0d) dir %0d exp (16,16) dir 0", px, py, bdir); end
    @(negedge clk) rst = 1'b0;
    run_tick(lat, nb, w3, w4);
    n_cmp++; if (lat !== -1 || px !== 10'd16) begin n_bad++; $display("FAIL midrst_tick got lat %0d x %0d exp -1 16", lat, px); end
  endtask

  initial begin
    test_reset();
    test_straight();
    test_launch_rules();
    test_x_bounce();
    test_corner();
    test_y_bounce();
    test_friction();
    test_back_to_back();
    test_reset_mid_reflect();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
